// File: rtl/bean_tracker_if.sv
// Signal bundle between the bean tracker and its neighbours: maze ROM,
// Pac-Man position source and the bean renderer's pixel read port.
interface bean_tracker_if;
  logic       reload;
  logic       score_clr;
  logic [8:0] init_addr;
  logic       init_wall;
  logic [9:0] pac_x;
  logic [9:0] pac_y;
  logic       pac_valid;
  logic [9:0] p_x;
  logic [9:0] p_y;
  logic [9:0] bean_l;
  logic [9:0] bean_b;
  logic       bean_alive;
  logic       eat;
  logic [13:0] score;
  logic [8:0] remaining;
  logic       level_clear;
  logic       busy;

  modport master (
    output reload, score_clr, init_wall, pac_x, pac_y, pac_valid, p_x, p_y,
    input  init_addr, bean_l, bean_b, bean_alive, eat, score, remaining,
           level_clear, busy
  );

  modport slave (
    input  reload, score_clr, init_wall, pac_x, pac_y, pac_valid, p_x, p_y,
    output init_addr, bean_l, bean_b, bean_alive, eat, score, remaining,
           level_clear, busy
  );
endinterface

// File: rtl/bean_tracker.sv
// Live bean bitmap for the maze: loads from the wall ROM, clears beans as
// Pac-Man eats them, keeps score/remaining count and serves the pixel read port.
module bean_tracker #(
  parameter int GRID_W     = 20,
  parameter int GRID_H     = 15,
  parameter int CELL_SHIFT = 5,
  parameter int BEAN_OFS   = 11,
  parameter int POINTS     = 10,
  parameter int SCORE_MAX  = 9999
) (
  input  logic clk,
  input  logic rst_n,
  bean_tracker_if.slave bus
);

  localparam int         CELLS = GRID_W * GRID_H;
  localparam int         PAD   = 512;
  localparam logic [8:0] LAST  = 9'(CELLS - 1);

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  logic [1:0]       state_reg;
  logic [8:0]       init_addr_reg;
  logic [8:0]       remaining_reg;
  logic [13:0]      score_reg;
  logic             eat_reg;
  logic [CELLS-1:0] bitmap_reg;
  logic [9:0]       bean_l_reg;
  logic [9:0]       bean_b_reg;
  logic             bean_alive_reg;

  // Zero-padded view so any 9-bit index selects a defined bit.
  logic [PAD-1:0] bitmap_pad;
  assign bitmap_pad = PAD'(bitmap_reg);

  logic [9:0] pac_col, pac_row;
  logic [8:0] pac_idx;
  logic       pac_in_range;
  logic       hit;
  logic       init_wr;

  assign pac_col      = bus.pac_x >> CELL_SHIFT;
  assign pac_row      = bus.pac_y >> CELL_SHIFT;
  assign pac_idx      = 9'(pac_row * 10'(GRID_W) + pac_col);
  assign pac_in_range = (pac_col < 10'(GRID_W)) && (pac_row < 10'(GRID_H));

  // reload outranks both the eat path and the current load cycle.
  assign hit     = (state_reg == ST_PLAY) && bus.pac_valid && !bus.reload &&
                   pac_in_range && bitmap_pad[pac_idx];
  assign init_wr = (state_reg == ST_INIT) && !bus.reload;

  logic [14:0] score_sum;
  logic [13:0] score_sat;
  logic [8:0]  rem_inc;

  assign score_sum = 15'({1'b0, score_reg}) + 15'(POINTS);
  assign score_sat = (score_sum > 15'(SCORE_MAX)) ? 14'(SCORE_MAX) : score_sum[13:0];
  assign rem_inc   = remaining_reg + {8'd0, ~bus.init_wall};

  genvar gi;
  generate
    for (gi = 0; gi < CELLS; gi++) begin : g_cell
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bitmap_reg[gi] <= 1'b0;
        end else if (init_wr && init_addr_reg == 9'(gi)) begin
          bitmap_reg[gi] <= ~bus.init_wall;
        end else if (hit && pac_idx == 9'(gi)) begin
          bitmap_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_INIT;
      init_addr_reg <= 9'd0;
      remaining_reg <= 9'd0;
      score_reg     <= 14'd0;
      eat_reg       <= 1'b0;
    end else begin
      eat_reg <= hit;

      if (bus.score_clr) begin
        score_reg <= 14'd0;
      end else if (hit) begin
        score_reg <= score_sat;
      end

      if (bus.reload) begin
        state_reg     <= ST_INIT;
        init_addr_reg <= 9'd0;
        remaining_reg <= 9'd0;
      end else begin
        case (state_reg)
          ST_INIT: begin
            remaining_reg <= rem_inc;
            if (init_addr_reg == LAST) begin
              init_addr_reg <= 9'd0;
              state_reg     <= (rem_inc == 9'd0) ? ST_CLEAR : ST_PLAY;
            end else begin
              init_addr_reg <= init_addr_reg + 9'd1;
            end
          end
          ST_PLAY: begin
            if (hit) begin
              remaining_reg <= remaining_reg - 9'd1;
              if (remaining_reg == 9'd1) begin
                state_reg <= ST_CLEAR;
              end
            end
          end
          ST_CLEAR: begin
            state_reg <= ST_CLEAR;
          end
          default: begin
            state_reg <= ST_INIT;
          end
        endcase
      end
    end
  end

  logic [9:0] px_col, px_row;
  logic [8:0] rd_idx;
  logic       on_screen;

  assign px_col    = bus.p_x >> CELL_SHIFT;
  assign px_row    = bus.p_y >> CELL_SHIFT;
  assign rd_idx    = 9'(px_row * 10'(GRID_W) + px_col);
  assign on_screen = (bus.p_x < 10'(GRID_W << CELL_SHIFT)) &&
                     (bus.p_y < 10'(GRID_H << CELL_SHIFT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bean_l_reg     <= 10'd0;
      bean_b_reg     <= 10'd0;
      bean_alive_reg <= 1'b0;
    end else begin
      bean_l_reg     <= 10'((px_col << CELL_SHIFT) + BEAN_OFS);
      bean_b_reg     <= 10'((px_row << CELL_SHIFT) + BEAN_OFS);
      bean_alive_reg <= on_screen && bitmap_pad[rd_idx];
    end
  end

  assign bus.init_addr   = init_addr_reg;
  assign bus.eat         = eat_reg;
  assign bus.score       = score_reg;
  assign bus.remaining   = remaining_reg;
  assign bus.level_clear = (state_reg == ST_CLEAR);
  assign bus.busy        = (state_reg == ST_INIT);
  assign bus.bean_l      = bean_l_reg;
  assign bus.bean_b      = bean_b_reg;
  assign bus.bean_alive  = bean_alive_reg;

endmodule
